mem_arb: RTL and testbench

Memory arbiter that shares the single main-memory port between the RISC5 CPU and the video refresh fetcher. Sits between the CPU bus (adr/rd/wr/ben/outbus) and the RAM, and generates the CPU stall signal that is currently tied low. Video refresh has priority; the CPU is stalled while its access waits or is in flight. Memory is a request/acknowledge device, so both fast on-chip RAM and multi-cycle external SRAM are supported.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb.sv | 134 +++++++++++++
 tb/tb_mem_arb.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb shared types: arbiter states, byte-lane enable helper, default widths.
package mem_arb_pkg;

   localparam int DEF_AW = 22;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      VID  = 2'd1,
      CPU  = 2'd2,
      DONE = 2'd3
   } state_t;

   function automatic logic [3:0] lane_be(input logic ben, input logic [1:0] sel);
      return ben ? (4'b0001 << sel) : 4'hF;
   endfunction

endpackage

// File: rtl/mem_arb.sv
// Main-memory arbiter between the CPU bus and the video refresh fetcher.
// Optional CPU starvation guard: define MEM_ARB_STARVE_EN.
module mem_arb
   import mem_arb_pkg::*;
#(
   parameter int AW      = DEF_AW,
   parameter int MAX_VID = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [23:0]   cpu_adr,
   input  logic          cpu_rd,
   input  logic          cpu_wr,
   input  logic          cpu_ben,
   input  logic [31:0]   cpu_wdata,
   output logic [31:0]   cpu_rdata,
   output logic          cpu_stall,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_adr,
   output logic          vid_ack,
   output logic [31:0]   vid_rdata,
   output logic          mem_req,
   output logic          mem_we,
   output logic [3:0]    mem_be,
   output logic [AW-1:0] mem_adr,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata,
   input  logic          mem_ack
);

   state_t state, state_nxt;
   logic   cpu_req;
   logic   starved;
   logic   unused_adr;

   assign cpu_req    = cpu_rd | cpu_wr;
   assign unused_adr = &{1'b0, cpu_adr};

`ifdef MEM_ARB_STARVE_EN
   localparam int CW = $clog2(MAX_VID + 1);

   logic [CW-1:0] starve_cnt;

   assign starved = cpu_req && (starve_cnt == CW'(MAX_VID));

   // counts video grants taken while the CPU was already waiting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (state == IDLE) begin
         if (state_nxt == CPU) begin
            starve_cnt <= '0;
         end else if (state_nxt == VID && cpu_req &&
                      starve_cnt != CW'(MAX_VID)) begin
            starve_cnt <= starve_cnt + 1'b1;
         end
      end
   end
`else
   localparam int unused_max_vid = MAX_VID;

   assign starved = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (vid_req && !starved) begin
               state_nxt = VID;
            end else if (cpu_req) begin
               state_nxt = CPU;
            end
         end
         VID: begin
            if (mem_ack) state_nxt = IDLE;
         end
         CPU: begin
            if (mem_ack) state_nxt = DONE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_be    = 4'h0;
      mem_adr   = '0;
      mem_wdata = '0;
      vid_ack   = 1'b0;
      unique case (state)
         VID: begin
            mem_req = 1'b1;
            mem_be  = 4'hF;
            mem_adr = vid_adr;
            vid_ack = mem_ack;
         end
         CPU: begin
            mem_req   = 1'b1;
            mem_we    = cpu_wr;
            mem_be    = lane_be(cpu_ben, cpu_adr[1:0]);
            mem_adr   = cpu_adr[AW+1:2];
            mem_wdata = cpu_ben ? {4{cpu_wdata[7:0]}} : cpu_wdata;
         end
         default: begin
         end
      endcase
   end

   assign cpu_stall = cpu_req && (state != DONE);
   assign vid_rdata = mem_rdata;

   // a write wins when rd and wr are both raised, so only pure reads load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpu_rdata <= '0;
      end else if (state == CPU && mem_ack && !cpu_wr) begin
         cpu_rdata <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb with a small request/ack memory model.
// Expected values are hand-derived from the arbitration timeline.
module tb_mem_arb;

   localparam int AW = 22;

   logic          clk;
   logic          rst_n;
   logic [23:0]   cpu_adr;
   logic          cpu_rd;
   logic          cpu_wr;
   logic          cpu_ben;
   logic [31:0]   cpu_wdata;
   logic [31:0]   cpu_rdata;
   logic          cpu_stall;
   logic          vid_req;
   logic [AW-1:0] vid_adr;
   logic          vid_ack;
   logic [31:0]   vid_rdata;
   logic          mem_req;
   logic          mem_we;
   logic [3:0]    mem_be;
   logic [AW-1:0] mem_adr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;
   logic          mem_ack;

   int          errs;
   int          checks;
   int          wait_cyc;
   int          wcnt;
   logic        clr;
   logic [31:0] mem [256];

   mem_arb #(.AW(AW), .MAX_VID(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_adr   (cpu_adr),
      .cpu_rd    (cpu_rd),
      .cpu_wr    (cpu_wr),
      .cpu_ben   (cpu_ben),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_stall (cpu_stall),
      .vid_req   (vid_req),
      .vid_adr   (vid_adr),
      .vid_ack   (vid_ack),
      .vid_rdata (vid_rdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_be    (mem_be),
      .mem_adr   (mem_adr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_ack   = mem_req && (wcnt == wait_cyc);
   assign mem_rdata = mem[mem_adr[7:0]];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) wcnt <= 0;
      else if (mem_req && mem_ack) wcnt <= 0;
      else if (mem_req) wcnt <= wcnt + 1;
      else wcnt <= 0;
   end

   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      end else if (mem_req && mem_ack && mem_we) begin
         for (int b = 0; b < 4; b++)
            if (mem_be[b]) mem[mem_adr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cpu_go(input logic rd, input logic wr, input logic ben,
                         input logic [23:0] adr, input logic [31:0] wd);
      cpu_rd    = rd;
      cpu_wr    = wr;
      cpu_ben   = ben;
      cpu_adr   = adr;
      cpu_wdata = wd;
      tick();
   endtask

   task automatic cpu_wait(output int n);
      n = 0;
      while (cpu_stall && n < 100) begin
         tick();
         n++;
      end
   endtask

   task automatic cpu_end();
      cpu_rd  = 1'b0;
      cpu_wr  = 1'b0;
      cpu_ben = 1'b0;
      tick();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      int          acks;
      int          first;
      logic [31:0] vrd;

      errs      = 0;
      checks    = 0;
      wait_cyc  = 0;
      clr       = 1'b1;
      rst_n     = 1'b0;
      cpu_adr   = '0;
      cpu_rd    = 1'b0;
      cpu_wr    = 1'b0;
      cpu_ben   = 1'b0;
      cpu_wdata = '0;
      vid_req   = 1'b0;
      vid_adr   = '0;

      tick();
      tick();
      chk("rst_mem_req", mem_req, 0);
      chk("rst_stall", cpu_stall, 0);
      chk("rst_rdata", cpu_rdata, 0);
      chk("rst_vid_ack", vid_ack, 0);
      clr   = 1'b0;
      rst_n = 1'b1;
      tick();

      // reset in the middle of a slow CPU access
      wait_cyc = 5;
      cpu_go(1, 0, 0, 24'h000000, 0);
      chk("mid_mem_req", mem_req, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_req", mem_req, 0);
      cpu_rd = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      chk("post_rst_req", mem_req, 0);
      chk("post_rst_stall", cpu_stall, 0);
      chk("post_rst_rdata", cpu_rdata, 0);
      chk("post_rst_vack", vid_ack, 0);
      wait_cyc = 0;

      // word write, zero-wait
      cpu_go(0, 1, 0, 24'h000104, 32'hDEADBEEF);
      chk("ww_req", mem_req, 1);
      chk("ww_we", mem_we, 1);
      chk("ww_adr", 32'(mem_adr), 32'h41);
      chk("ww_be", 32'(mem_be), 32'hF);
      chk("ww_wdata", mem_wdata, 32'hDEADBEEF);
      chk("ww_stall", cpu_stall, 1);
      cpu_wait(n);
      chk("ww_stall_cyc", n, 1);
      chk("ww_done_req", mem_req, 0);
      cpu_end();

      // byte write to lane 3, then word read of the same word
      cpu_go(0, 1, 1, 24'h000103, 32'h0000005A);
      chk("bw_be", 32'(mem_be), 32'h8);
      chk("bw_wdata", mem_wdata, 32'h5A5A5A5A);
      chk("bw_adr", 32'(mem_adr), 32'h40);
      cpu_wait(n);
      cpu_end();
      cpu_go(1, 0, 0, 24'h000100, 0);
      chk("wr_we", mem_we, 0);
      cpu_wait(n);
      chk("wr_stall_cyc", n, 1);
      chk("wr_rdata", cpu_rdata, 32'h5A000000);
      cpu_end();

      // simultaneous video + CPU with 3 wait cycles
      wait_cyc = 3;
      vid_adr  = 22'h41;
      vid_req  = 1'b1;
      cpu_rd   = 1'b1;
      cpu_adr  = 24'h000100;
      n     = 0;
      acks  = 0;
      first = 0;
      vrd   = '0;
      while (n < 100) begin
         tick();
         n++;
         if (n == 1) chk("sim_vid_adr", 32'(mem_adr), 32'h41);
         if (vid_ack) begin
            acks++;
            first = n;
            vrd = vid_rdata;
            vid_req = 1'b0;
         end
         if (!cpu_stall) break;
      end
      chk("sim_vid_acks", acks, 1);
      chk("sim_vid_ack_cyc", first, 4);
      chk("sim_vid_rdata", vrd, 32'hDEADBEEF);
      chk("sim_total_cyc", n, 10);
      chk("sim_cpu_rdata", cpu_rdata, 32'h5A000000);
      vid_req = 1'b0;
      cpu_end();
      wait_cyc = 0;

      // video held high continuously while the CPU waits
      vid_adr = 22'h41;
      vid_req = 1'b1;
      cpu_rd  = 1'b1;
      cpu_adr = 24'h000104;
      n    = 0;
      acks = 0;
      while (n < 100) begin
         tick();
         n++;
         if (vid_ack) acks++;
         if (!cpu_stall) break;
      end
`ifdef MEM_ARB_STARVE_EN
      chk("stv_vid_acks", acks, 8);
      chk("stv_cpu_cyc", n, 18);
      chk("stv_rdata", cpu_rdata, 32'hDEADBEEF);
      vid_req = 1'b0;
      cpu_end();
`else
      chk("stv_vid_acks", acks, 50);
      chk("stv_still_stall", cpu_stall, 1);
      vid_req = 1'b0;
      cpu_wait(n);
      chk("stv_late_cyc", n, 2);
      chk("stv_rdata", cpu_rdata, 32'hDEADBEEF);
      cpu_end();
`endif

      // byte read returns the raw word
      cpu_go(0, 1, 0, 24'h000000, 32'h11223344);
      cpu_wait(n);
      cpu_end();
      cpu_go(1, 0, 1, 24'h000002, 0);
      chk("br_be", 32'(mem_be), 32'h4);
      chk("br_we", mem_we, 0);
      cpu_wait(n);
      chk("br_rdata", cpu_rdata, 32'h11223344);
      cpu_end();

      // rd and wr together behave as a write
      cpu_go(1, 1, 0, 24'h000008, 32'hCAFEF00D);
      chk("rw_we", mem_we, 1);
      chk("rw_adr", 32'(mem_adr), 32'h2);
      cpu_wait(n);
      chk("rw_rdata_held", cpu_rdata, 32'h11223344);
      cpu_end();
      cpu_go(1, 0, 0, 24'h000008, 0);
      cpu_wait(n);
      chk("rw_readback", cpu_rdata, 32'hCAFEF00D);
      cpu_end();
      chk("end_idle_req", mem_req, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
